// File: rtl/hd_demux_pkg.sv
// Shared definitions for the registered 1:4 demultiplexer: lane count, lane index type, steering modes.
package hd_demux_pkg;

    localparam int unsigned NLANE  = 4;
    localparam int unsigned LANE_W = 2;

    typedef logic [LANE_W-1:0] lane_idx_t;

    localparam int unsigned RR_OFF = 0;
    localparam int unsigned RR_ON  = 1;

    // Round-robin successor; the 2-bit width makes 3 -> 0 wrap for free.
    function automatic lane_idx_t lane_next(input lane_idx_t p);
        return p + lane_idx_t'(1);
    endfunction

endpackage

// File: rtl/hd_lane_reg.sv
// One-deep output register slice for a single demux lane, with valid/ready drain.
module hd_lane_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         qv,
    input  logic         qr,
    output logic         free_c
);

    // A held beat that drains this cycle frees the slot for a same-cycle load.
    assign free_c = ~qv | qr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q  <= '0;
            qv <= 1'b0;
        end else if (ld) begin
            q  <= d;
            qv <= 1'b1;
        end else if (qv && qr) begin
            qv <= 1'b0;
        end
    end

endmodule

// File: rtl/hd_demux4_reg.sv
// Registered 1:4 valid/ready demultiplexer; lane chosen by {SL1,SL0} or by a round-robin pointer.
module hd_demux4_reg
    import hd_demux_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned MODE_RR = RR_OFF
) (
    input  logic         CK,
    input  logic         R,
    input  logic [W-1:0] A,
    input  logic         AV,
    output logic         AR,
    input  logic         SL0,
    input  logic         SL1,
    output logic [W-1:0] Z0,
    output logic [W-1:0] Z1,
    output logic [W-1:0] Z2,
    output logic [W-1:0] Z3,
    output logic         ZV0,
    output logic         ZV1,
    output logic         ZV2,
    output logic         ZV3,
    input  logic         ZR0,
    input  logic         ZR1,
    input  logic         ZR2,
    input  logic         ZR3
);

    lane_idx_t                   r_ptr;
    lane_idx_t                   w_lane;
    logic                        w_sel_ok;
    logic                        w_acc;
    logic [NLANE-1:0]            w_free;
    logic [NLANE-1:0]            w_ld;
    logic [NLANE-1:0]            w_zr;
    logic [NLANE-1:0]            w_zv;
    logic [NLANE-1:0][W-1:0]     w_z;

    assign w_zr   = {ZR3, ZR2, ZR1, ZR0};
    assign w_lane = (MODE_RR == RR_ON) ? r_ptr : {SL1, SL0};

    // Unknown select refuses the beat in simulation; folds to constant 1 in synthesis.
    assign w_sel_ok = (MODE_RR == RR_ON) || ((^{SL1, SL0}) !== 1'bx);

    assign AR    = w_sel_ok & w_free[w_lane];
    assign w_acc = AV & AR;

    for (genvar n = 0; n < NLANE; n++) begin : g_lane
        assign w_ld[n] = w_acc & (w_lane == lane_idx_t'(n));

        hd_lane_reg #(
            .W (W)
        ) u_lane (
            .clk    (CK),
            .rst    (R),
            .ld     (w_ld[n]),
            .d      (A),
            .q      (w_z[n]),
            .qv     (w_zv[n]),
            .qr     (w_zr[n]),
            .free_c (w_free[n])
        );
    end

    // Pointer moves only on an accepted beat, so a stalled lane keeps its turn.
    always_ff @(posedge CK or posedge R) begin
        if (R) begin
            r_ptr <= '0;
        end else if (w_acc) begin
            r_ptr <= lane_next(r_ptr);
        end
    end

    assign Z0  = w_z[0];
    assign Z1  = w_z[1];
    assign Z2  = w_z[2];
    assign Z3  = w_z[3];
    assign ZV0 = w_zv[0];
    assign ZV1 = w_zv[1];
    assign ZV2 = w_zv[2];
    assign ZV3 = w_zv[3];

endmodule

// File: tb/tb_hd_demux4_reg.sv
// Bench for hd_demux4_reg: select-mode and round-robin instances share stimulus, checked against a lane model.
`timescale 1ns/100ps
module tb_hd_demux4_reg;

    localparam int unsigned W = 8;

    logic         CK = 1'b0;
    logic         R  = 1'b1;
    logic [W-1:0] A;
    logic         AV;
    logic         SL0, SL1;
    logic [3:0]   ZR;

    logic                AR0, AR1;
    logic [3:0][W-1:0]   zd0, zd1;
    logic [3:0]          zv0, zv1;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mz  [2][4];
    bit           mzv [2][4];
    int           mptr[2];

    always #5 CK = ~CK;

    hd_demux4_reg #(.W(W), .MODE_RR(0)) u_sel (
        .CK(CK), .R(R), .A(A), .AV(AV), .AR(AR0), .SL0(SL0), .SL1(SL1),
        .Z0(zd0[0]), .Z1(zd0[1]), .Z2(zd0[2]), .Z3(zd0[3]),
        .ZV0(zv0[0]), .ZV1(zv0[1]), .ZV2(zv0[2]), .ZV3(zv0[3]),
        .ZR0(ZR[0]), .ZR1(ZR[1]), .ZR2(ZR[2]), .ZR3(ZR[3])
    );

    hd_demux4_reg #(.W(W), .MODE_RR(1)) u_rr (
        .CK(CK), .R(R), .A(A), .AV(AV), .AR(AR1), .SL0(SL0), .SL1(SL1),
        .Z0(zd1[0]), .Z1(zd1[1]), .Z2(zd1[2]), .Z3(zd1[3]),
        .ZV0(zv1[0]), .ZV1(zv1[1]), .ZV2(zv1[2]), .ZV3(zv1[3]),
        .ZR0(ZR[0]), .ZR1(ZR[1]), .ZR2(ZR[2]), .ZR3(ZR[3])
    );

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mptr[m] = 0;
            for (int n = 0; n < 4; n++) begin
                mz[m][n]  = '0;
                mzv[m][n] = 1'b0;
            end
        end
    endtask

    function automatic int lane_of(input int m);
        return (m == 1) ? mptr[m] : int'({SL1, SL0});
    endfunction

    function automatic bit model_ar(input int m);
        int l;
        l = lane_of(m);
        return !mzv[m][l] || ZR[l];
    endfunction

    // Reference: a beat lands in its lane when that lane is empty or draining; every full lane drains on ready.
    always @(posedge CK) begin
        if (!R) begin
            for (int m = 0; m < 2; m++) begin
                bit acc;
                int l;
                acc = AV && model_ar(m);
                l   = lane_of(m);
                for (int n = 0; n < 4; n++) begin
                    if (acc && n == l) begin
                        mz[m][n]  = A;
                        mzv[m][n] = 1'b1;
                    end else if (mzv[m][n] && ZR[n]) begin
                        mzv[m][n] = 1'b0;
                    end
                end
                if (acc) mptr[m] = (mptr[m] + 1) % 4;
            end
        end
    end

    always @(posedge R) model_reset();

    always @(negedge CK) begin
        check("u_sel.AR", int'(AR0), int'(model_ar(0)));
        check("u_rr.AR",  int'(AR1), int'(model_ar(1)));
        for (int n = 0; n < 4; n++) begin
            check($sformatf("u_sel.ZV%0d", n), int'(zv0[n]), int'(mzv[0][n]));
            check($sformatf("u_sel.Z%0d", n),  int'(zd0[n]), int'(mz[0][n]));
            check($sformatf("u_rr.ZV%0d", n),  int'(zv1[n]), int'(mzv[1][n]));
            check($sformatf("u_rr.Z%0d", n),   int'(zd1[n]), int'(mz[1][n]));
        end
    end

    task automatic cyc();
        @(posedge CK);
        #2;
    endtask

    initial begin
        model_reset();
        A  = 8'hFF;
        AV = 1'b1;
        {SL1, SL0} = 2'd0;
        ZR = 4'hF;
        repeat (2) @(posedge CK);
        #2;
        for (int n = 0; n < 4; n++) begin
            check("rst.ZV", int'(zv0[n]), 0);
            check("rst.Z",  int'(zd0[n]), 0);
            check("rst.rr.ZV", int'(zv1[n]), 0);
        end
        R = 1'b0;
        A = 8'h55;
        cyc();
        check("rst.first_rr.ZV0", int'(zv1[0]), 1);
        check("rst.first_rr.Z0",  int'(zd1[0]), 8'h55);

        // Select steering
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] v;
            v = W'(8'h10 + i * 8'h11);
            A = v;
            {SL1, SL0} = 2'(i);
            AV = 1'b1;
            cyc();
            check($sformatf("steer.ZV%0d", i), int'(zv0[i]), 1);
            check($sformatf("steer.Z%0d", i),  int'(zd0[i]), int'(v));
        end
        AV = 1'b0;
        cyc();
        check("steer.drained", int'(zv0), 0);

        // Back-pressure on lane 2
        ZR = 4'b1011;
        {SL1, SL0} = 2'd2;
        A = 8'hA0;
        AV = 1'b1;
        #1 check("bp.AR_first", int'(AR0), 1);
        cyc();
        check("bp.Z2_A0", int'(zd0[2]), 8'hA0);
        A = 8'hA1;
        #1 check("bp.AR_stall", int'(AR0), 0);
        cyc();
        check("bp.Z2_held", int'(zd0[2]), 8'hA0);
        check("bp.ZV2_held", int'(zv0[2]), 1);
        {SL1, SL0} = 2'd1;
        A = 8'hB1;
        #1 check("bp.AR_lane1", int'(AR0), 1);
        cyc();
        check("bp.Z1_B1", int'(zd0[1]), 8'hB1);
        {SL1, SL0} = 2'd2;
        A = 8'hA1;
        ZR = 4'hF;
        #1 check("bp.AR_release", int'(AR0), 1);
        cyc();
        check("bp.Z2_A1", int'(zd0[2]), 8'hA1);
        check("bp.ZV2_A1", int'(zv0[2]), 1);
        AV = 1'b0;
        cyc();

        // Round-robin wrap with lane 2 held
        R = 1'b1;
        #1 R = 1'b0;
        ZR = 4'b1011;
        AV = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            int l;
            l = (i - 1) % 4;
            A = W'(i);
            cyc();
            check($sformatf("rr.beat%0d.ZV", i), int'(zv1[l]), 1);
            check($sformatf("rr.beat%0d.Z", i),  int'(zd1[l]), i);
        end
        A = 8'h07;
        #1 check("rr.stall_AR", int'(AR1), 0);
        cyc();
        cyc();
        check("rr.stall_Z2", int'(zd1[2]), 8'h03);
        ZR = 4'hF;
        #1 check("rr.release_AR", int'(AR1), 1);
        cyc();
        check("rr.ptr_held_Z2", int'(zd1[2]), 8'h07);
        check("rr.ptr_held_ZV2", int'(zv1[2]), 1);
        AV = 1'b0;
        cyc();

        // Streaming into lane 3
        {SL1, SL0} = 2'd3;
        for (int i = 0; i < 8; i++) begin
            A = W'(8'hC0 + i);
            AV = 1'b1;
            #1 check("stream.AR", int'(AR0), 1);
            cyc();
            check("stream.ZV3", int'(zv0[3]), 1);
            check("stream.Z3",  int'(zd0[3]), 8'hC0 + i);
        end
        AV = 1'b0;
        cyc();

        // Asynchronous reset with held beats
        ZR = 4'h0;
        {SL1, SL0} = 2'd0;
        A = 8'hE0;
        AV = 1'b1;
        cyc();
        {SL1, SL0} = 2'd3;
        A = 8'hE3;
        cyc();
        AV = 1'b0;
        check("mid.ZV0_full", int'(zv0[0]), 1);
        check("mid.ZV3_full", int'(zv0[3]), 1);
        #4 R = 1'b1;
        #1;
        check("mid.ZV0_clear", int'(zv0[0]), 0);
        check("mid.ZV3_clear", int'(zv0[3]), 0);
        R = 1'b0;
        cyc();
        ZR = 4'hF;
        A = 8'h5A;
        AV = 1'b1;
        cyc();
        check("mid.ptr0_ZV0", int'(zv1[0]), 1);
        check("mid.ptr0_Z0",  int'(zd1[0]), 8'h5A);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            A  = W'($urandom);
            AV = ($urandom_range(0, 3) != 0);
            {SL1, SL0} = 2'($urandom_range(0, 3));
            for (int n = 0; n < 4; n++) ZR[n] = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 96) == 0) begin
                R = 1'b1;
                #1 R = 1'b0;
            end
            cyc();
        end

        AV = 1'b0;
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
